// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter that shares one main-memory port between
// the icache refill path and the dcache refill/writeback path.
// One transaction per requester at a time. Every output is registered.
// Optional build macro IMEM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// completes a stuck transaction with an error flag after TIMEOUT_CYCLES.
module imem_arbiter #(
  parameter int unsigned ADDR_W         = 20,
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  // icache refill port
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_err,
  // dcache refill / writeback port
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_err,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {REQ_IC = 1'b0, REQ_DC = 1'b1} req_id_e;

  state_e            state_q, state_d;
  req_id_e           winner_q, winner_d;
  req_id_e           rr_last_q, rr_last_d;
  req_id_e           grant;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;

`ifdef IMEM_ARB_TIMEOUT_EN
  // The watchdog fires on the WAIT cycle whose count would reach the limit.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       ic_err_q, ic_err_d;
  logic       dc_err_q, dc_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    if (ic_req && dc_req) grant = (rr_last_q == REQ_DC) ? REQ_IC : REQ_DC;
    else if (ic_req)      grant = REQ_IC;
    else                  grant = REQ_DC;
  end

  // Next-state and registered-output logic of the IDLE/WAIT/RESP handshake.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d     = state_q;
    winner_d    = winner_q;
    rr_last_d   = rr_last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
    ic_err_d    = 1'b0;
    dc_err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          winner_d  = grant;
          mem_req_d = 1'b1;
          state_d   = WAIT;
`ifdef IMEM_ARB_TIMEOUT_EN
          wdog_d    = 8'd0;
`endif
          if (grant == REQ_DC) begin
            mem_we_d    = dc_we;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = ic_addr;
            mem_wdata_d = '0;
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          rr_last_d = winner_q;
          state_d   = RESP;
          if (winner_q == REQ_DC) begin
            dc_ready_d = 1'b1;
            if (!mem_we_q) dc_rdata_d = mem_rdata;
          end else begin
            ic_ready_d = 1'b1;
            ic_rdata_d = mem_rdata;
          end
        end
`ifdef IMEM_ARB_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          // Abandon the access: complete with err, rdata left untouched.
          mem_req_d = 1'b0;
          rr_last_d = winner_q;
          state_d   = RESP;
          if (winner_q == REQ_DC) begin
            dc_ready_d = 1'b1;
            dc_err_d   = 1'b1;
          end else begin
            ic_ready_d = 1'b1;
            ic_err_d   = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end

      RESP: begin
        // Requests are not sampled here; this also keeps mem_req low for a cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      winner_q    <= REQ_IC;
      rr_last_q   <= REQ_DC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_last_q   <= rr_last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

`ifdef IMEM_ARB_TIMEOUT_EN
  // Watchdog counter and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q   <= 8'd0;
      ic_err_q <= 1'b0;
      dc_err_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      ic_err_q <= ic_err_d;
      dc_err_q <= dc_err_d;
    end
  end

  assign ic_err = ic_err_q;
  assign dc_err = dc_err_q;
`else
  assign ic_err = 1'b0;
  assign dc_err = 1'b0;
`endif

  assign ic_ready  = ic_ready_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_ready  = dc_ready_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: random icache/dcache traffic against a memory
// responder with random ack delays and spurious acks. Expected responses are
// queued at issue time and compared by an independent monitor on each ready.
module tb_imem_arbiter;

  localparam int AW = 20;
  localparam int DW = 128;
  localparam int TO = 8;
  localparam int N_TX = 24;
  localparam logic ID_IC = 1'b0;
  localparam logic ID_DC = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_ready, ic_err;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          dc_req, dc_we, dc_ready, dc_err;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata, dc_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready),
    .ic_rdata(ic_rdata), .ic_err(ic_err),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata), .dc_err(dc_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rise_cyc;
    int            ack_cyc;
  } log_t;

  exp_t ic_q[$];
  exp_t dc_q[$];
  log_t mem_log[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mem_en = 1'b0;
  logic samp_ic = 1'b0, samp_dc = 1'b0;
  logic last_win = ID_DC;
  logic [DW-1:0] last_ic = '0, last_dc = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
    return {12'hDEA, a, 32'hBEEF_0000 ^ {12'h0, a}, ~{12'h0, a}, {a, 12'h5A5}};
  endfunction

  function automatic logic [DW-1:0] mem_value(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : hash(a);
  endfunction

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycle counter and request levels seen at each active edge.
  always @(posedge clk) begin
    cyc++;
    samp_ic = ic_req;
    samp_dc = dc_req;
  end

  // Memory responder: logs each new mem_req, checks the round-robin choice, acks.
  initial begin : responder
    logic prev_req = 1'b0;
    bit   pending = 1'b0;
    int   delay = 0;
    logic exp_id;
    log_t cur;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        mem_ack = 1'b0;
        mem_rdata = rand128();
      end
      if (mem_req && !prev_req) begin
        cur.id = mem_addr[AW-1];
        cur.we = mem_we;
        cur.addr = mem_addr;
        cur.wdata = mem_wdata;
        cur.rise_cyc = cyc;
        cur.ack_cyc = -1;
        exp_id = (samp_ic && samp_dc) ? ~last_win : (samp_ic ? ID_IC : ID_DC);
        check("rr_grant", cur.id, exp_id);
        last_win = cur.id;
        if (mem_en) begin
          pending = 1'b1;
          delay = $urandom_range(0, 3);
        end else begin
          mem_log.push_back(cur);
        end
      end
      prev_req = mem_req;
      if (mem_en && pending) begin
        if (delay == 0) begin
          mem_ack = 1'b1;
          if (cur.we) mem[cur.addr] = cur.wdata;
          else        mem_rdata = mem_value(cur.addr);
          cur.ack_cyc = cyc;
          mem_log.push_back(cur);
          pending = 1'b0;
        end else begin
          delay--;
        end
      end else if (mem_en && !mem_req && ($urandom_range(0, 4) == 0)) begin
        mem_ack = 1'b1;  // spurious ack outside WAIT
      end
    end
  end

  task automatic score(input logic id, input logic [DW-1:0] rdata, input logic err,
                       input logic other_ready);
    exp_t e;
    log_t l;
    string p;
    p = (id == ID_DC) ? "dc" : "ic";
    if ((id == ID_DC) ? (dc_q.size() == 0) : (ic_q.size() == 0)) begin
      check({p, "_unexpected_ready"}, 1'b1, 1'b0);
      return;
    end
    e = (id == ID_DC) ? dc_q.pop_front() : ic_q.pop_front();
    check({p, "_rdata"}, rdata, e.rdata);
    check({p, "_err"}, err, e.err);
    check({p, "_ready_exclusive"}, other_ready, 1'b0);
    check({p, "_mem_req_low_in_resp"}, mem_req, 1'b0);
    if (mem_log.size() == 0) begin
      check({p, "_no_mem_txn"}, 1'b1, 1'b0);
      return;
    end
    l = mem_log.pop_front();
    check({p, "_txn_owner"}, l.id, id);
    check({p, "_mem_addr"}, l.addr, e.addr);
    check({p, "_mem_we"}, l.we, e.we);
    if (e.we) check({p, "_mem_wdata"}, l.wdata, e.wdata);
    if (e.err) check({p, "_timeout_latency"}, cyc, l.rise_cyc + TO);
    else       check({p, "_ack_to_ready"}, cyc, l.ack_cyc + 1);
  endtask

  // Monitor: scores every ready pulse against the head of the expected queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ic_ready) score(ID_IC, ic_rdata, ic_err, dc_ready);
      if (dc_ready) score(ID_DC, dc_rdata, dc_err, ic_ready);
    end
  end

  task automatic ic_drive();
    exp_t e;
    for (int i = 0; i < N_TX; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      e.we = 1'b0;
      e.addr = $urandom & 20'h7FFF0;
      e.wdata = '0;
      e.rdata = hash(e.addr);
      e.err = 1'b0;
      last_ic = e.rdata;
      ic_q.push_back(e);
      ic_addr = e.addr;
      ic_req = 1'b1;
      begin : wait_ic
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (ic_ready) disable wait_ic;
        end
        check("ic_ready_timeout", 1'b0, 1'b1);
      end
      ic_req = 1'b0;
    end
  endtask

  task automatic dc_drive();
    exp_t e;
    for (int i = 0; i < N_TX; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      e.we = $urandom_range(0, 1);
      e.addr = 20'h80000 | 20'(($urandom % 8) << 4);
      e.wdata = rand128();
      e.err = 1'b0;
      if (e.we) begin
        e.rdata = last_dc;
      end else begin
        e.rdata = mem_value(e.addr);
        last_dc = e.rdata;
      end
      dc_q.push_back(e);
      dc_we = e.we;
      dc_addr = e.addr;
      dc_wdata = e.wdata;
      dc_req = 1'b1;
      begin : wait_dc
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (dc_ready) disable wait_dc;
        end
        check("dc_ready_timeout", 1'b0, 1'b1);
      end
      dc_req = 1'b0;
    end
  endtask

  initial begin : main
    rst = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ic_ready", ic_ready, 1'b0);
    check("rst_dc_ready", dc_ready, 1'b0);
    check("rst_ic_rdata", ic_rdata, '0);
    check("rst_dc_rdata", dc_rdata, '0);
    rst = 1'b1;

    // Asynchronous reset in the middle of WAIT abandons the access.
    @(negedge clk);
    ic_addr = 20'h00040;
    ic_req = 1'b1;
    begin : wait_grant
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (mem_req) disable wait_grant;
      end
      check("grant_timeout", 1'b0, 1'b1);
    end
    check("wait_mem_req", mem_req, 1'b1);
    check("wait_mem_addr", mem_addr, 20'h00040);
    check("wait_mem_we", mem_we, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_mem_we", mem_we, 1'b0);
    check("arst_mem_addr", mem_addr, '0);
    check("arst_mem_wdata", mem_wdata, '0);
    check("arst_ic_ready", ic_ready, 1'b0);
    check("arst_dc_ready", dc_ready, 1'b0);
    check("arst_ic_err", ic_err, 1'b0);
    check("arst_dc_err", dc_err, 1'b0);
    check("arst_ic_rdata", ic_rdata, '0);
    check("arst_dc_rdata", dc_rdata, '0);
    @(negedge clk);
    ic_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_log.delete();
    last_win = ID_DC;

    // Random concurrent traffic.
    mem_en = 1'b1;
    fork
      ic_drive();
      dc_drive();
    join
    repeat (6) @(negedge clk);
    check("ic_queue_drained", 32'(ic_q.size()), 32'd0);
    check("dc_queue_drained", 32'(dc_q.size()), 32'd0);
    check("mem_log_drained", 32'(mem_log.size()), 32'd0);
    check("idle_mem_req", mem_req, 1'b0);

`ifdef IMEM_ARB_TIMEOUT_EN
    // Withheld ack: watchdog completes with err; a late ack is ignored.
    begin
      exp_t e;
      mem_en = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0;
      e.we = 1'b0; e.addr = 20'h00100; e.wdata = '0;
      e.rdata = last_ic; e.err = 1'b1;
      ic_q.push_back(e);
      ic_addr = e.addr;
      ic_req = 1'b1;
      begin : wait_to
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (ic_ready) disable wait_to;
        end
        check("timeout_ready_missing", 1'b0, 1'b1);
      end
      ic_req = 1'b0;
      @(negedge clk);
      check("timeout_err_clears", ic_err, 1'b0);
      mem_ack = 1'b1;
      mem_rdata = rand128();
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("late_ack_mem_req", mem_req, 1'b0);
      check("late_ack_ic_rdata", ic_rdata, last_ic);
      check("timeout_queue_drained", 32'(ic_q.size()), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : global_watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
